mult_share_ctrl: RTL

Controller that shares one signed 32x32 multiplier between two requesters in the RISC execute stage (e.g. integer pipe and address/MAC unit). Round-robin arbitration, registered operand issue, a fixed settling count for the multiplier, and a held 64-bit response with a valid/ready handshake. One operation is in flight at a time.

---
 rtl/mult_share_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/mult_share_ctrl.sv
// Round-robin controller sharing one 32x32 multiplier between two requesters.
// Optional MULT_SHARE_UNSIGNED_EN adds per-request unsigned select (mul_uns).
module mult_share_ctrl #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
`ifdef MULT_SHARE_UNSIGNED_EN
    input  logic        req0_uns,
    input  logic        req1_uns,
    output logic        mul_uns,
`endif
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_y,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [63:0] resp_y,
    input  logic        resp_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // LAT is limited to 1..15 so it fits the 4-bit settling counter
    localparam logic [3:0] LAT_C = 4'(LAT);

    state_t     state;
    logic [3:0] cnt;
    logic       prio;
    logic       owner;
    logic       grant0;
    logic       grant1;

    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~prio);
        grant1 = req1_valid & (~req0_valid | prio);
    end

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            prio       <= 1'b0;
            owner      <= 1'b0;
            mul_a      <= 32'd0;
            mul_b      <= 32'd0;
            resp_y     <= 64'd0;
            resp_id    <= 1'b0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef MULT_SHARE_UNSIGNED_EN
            mul_uns    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        cnt   <= LAT_C;
                        owner <= grant1;
                        prio  <= ~grant1;
                        mul_a <= grant1 ? req1_a : req0_a;
                        mul_b <= grant1 ? req1_b : req0_b;
`ifdef MULT_SHARE_UNSIGNED_EN
                        mul_uns <= grant1 ? req1_uns : req0_uns;
`endif
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        resp_y     <= mul_y;
                        resp_id    <= owner;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
